// File: rtl/hex_scan_ctrl.sv
// Six-digit HEX display scan controller: captures a 24-bit value, then writes one digit per
// clock through a single shared 7-segment decoder, with per-digit blanking and global blink.
module hex_scan_ctrl #(
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [23:0] value,
    input  logic [5:0]  blank_mask,
    input  logic        blink_en,
    output logic        busy,
    output logic        done,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5
);

    localparam int unsigned CntW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(BLINK_DIV - 1);
    localparam logic [6:0] SegBlank = 7'b1111111;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [2:0]      r_idx;
    logic [2:0]      w_idx_next;
    logic [23:0]     r_value;
    logic [5:0]      r_mask;
    logic [6:0]      r_digit [6];
    logic            w_capture;
    logic            w_write;
    logic [3:0]      w_nibble;
    logic            w_mask_bit;
    logic [6:0]      w_seg;
    logic [CntW-1:0] r_cnt;
    logic            r_phase;
    logic            w_dark;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        unique case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // The one shared decoder, fed by the idx mux over the captured value.
    always_comb begin
        w_nibble   = 4'h0;
        w_mask_bit = 1'b0;
        case (r_idx)
            3'd0: begin w_nibble = r_value[3:0];   w_mask_bit = r_mask[0]; end
            3'd1: begin w_nibble = r_value[7:4];   w_mask_bit = r_mask[1]; end
            3'd2: begin w_nibble = r_value[11:8];  w_mask_bit = r_mask[2]; end
            3'd3: begin w_nibble = r_value[15:12]; w_mask_bit = r_mask[3]; end
            3'd4: begin w_nibble = r_value[19:16]; w_mask_bit = r_mask[4]; end
            3'd5: begin w_nibble = r_value[23:20]; w_mask_bit = r_mask[5]; end
            default: begin w_nibble = 4'h0;        w_mask_bit = 1'b1;      end
        endcase
        w_seg = w_mask_bit ? SegBlank : seg_decode(w_nibble);
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_capture    = 1'b0;
        w_write      = 1'b0;
        case (r_state)
            StIdle: begin
                if (load) begin
                    w_capture    = 1'b1;
                    w_idx_next   = 3'd0;
                    w_state_next = StScan;
                end
            end
            StScan: begin
                w_write    = 1'b1;
                w_idx_next = r_idx + 3'd1;
                if (r_idx == 3'd5) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_idx   <= 3'd0;
            r_value <= 24'h0;
            r_mask  <= 6'h0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            if (w_capture) begin
                r_value <= value;
                r_mask  <= blank_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < 6; n++) begin
            if (reset) begin
                r_digit[n] <= SegBlank;
            end else if (w_write && (r_idx == 3'(n))) begin
                r_digit[n] <= w_seg;
            end
        end
    end

    // Free-running blink divider; independent of the scan state machine.
    always_ff @(posedge clk) begin
        if (reset || !blink_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == CntMax) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_dark = blink_en && r_phase;
        busy   = (r_state != StIdle);
        done   = (r_state == StDone);
        HEX0   = w_dark ? SegBlank : r_digit[0];
        HEX1   = w_dark ? SegBlank : r_digit[1];
        HEX2   = w_dark ? SegBlank : r_digit[2];
        HEX3   = w_dark ? SegBlank : r_digit[3];
        HEX4   = w_dark ? SegBlank : r_digit[4];
        HEX5   = w_dark ? SegBlank : r_digit[5];
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed bench for hex_scan_ctrl: expected per-cycle outputs are queued when stimulus is
// driven and popped at each falling edge for comparison.
module tb_hex_scan_ctrl;

    localparam int unsigned BlinkDiv = 4;
    localparam logic [6:0] Blank = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [23:0] value;
    logic [5:0]  blank_mask;
    logic        blink_en;
    logic        busy;
    logic        done;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    hex_scan_ctrl #(
        .BLINK_DIV(BlinkDiv)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .blink_en   (blink_en),
        .busy       (busy),
        .done       (done),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .HEX4       (HEX4),
        .HEX5       (HEX5)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [41:0] hex;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [6:0] m_dig [6];
    int         m_cnt;
    logic       m_phase;

    function automatic logic [41:0] model_hex();
        logic [41:0] h;
        for (int n = 0; n < 6; n++) begin
            h[7*n +: 7] = (blink_en && m_phase) ? Blank : m_dig[n];
        end
        return h;
    endfunction

    // One clock edge's worth of expected state, given the current blink_en level.
    task automatic push(input logic b, input logic d);
        exp_t e;
        if (blink_en) begin
            if (m_cnt == BlinkDiv - 1) begin
                m_cnt   = 0;
                m_phase = ~m_phase;
            end else begin
                m_cnt++;
            end
        end else begin
            m_cnt   = 0;
            m_phase = 1'b0;
        end
        e.hex  = model_hex();
        e.busy = b;
        e.done = d;
        sb.push_back(e);
    endtask

    task automatic push_reset();
        exp_t e;
        for (int n = 0; n < 6; n++) m_dig[n] = Blank;
        m_cnt   = 0;
        m_phase = 1'b0;
        e.hex   = model_hex();
        e.busy  = 1'b0;
        e.done  = 1'b0;
        sb.push_back(e);
    endtask

    // Expectations for the load edge and the first n_dig digit writes (full scan adds DONE->IDLE).
    task automatic push_scan(input logic [23:0] v, input logic [5:0] m, input int n_dig);
        push(1'b1, 1'b0);
        for (int n = 0; n < n_dig; n++) begin
            m_dig[n] = m[n] ? Blank : seg_tab[v[4*n +: 4]];
            push(1'b1, n == 5);
        end
        if (n_dig == 6) push(1'b0, 1'b0);
    endtask

    function automatic logic [41:0] obs_hex();
        return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    task automatic tick(input string tag);
        exp_t e;
        logic [41:0] o;
        @(posedge clk);
        @(negedge clk);
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard empty: observed size %0d, required nonzero", tag, sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            o = obs_hex();
            checks++;
            assert (o === e.hex) else begin
                errors++;
                $error("FAIL %s hex observed=%h expected=%h", tag, o, e.hex);
            end
            checks++;
            assert (busy === e.busy) else begin
                errors++;
                $error("FAIL %s busy observed=%b expected=%b", tag, busy, e.busy);
            end
            checks++;
            assert (done === e.done) else begin
                errors++;
                $error("FAIL %s done observed=%b expected=%b", tag, done, e.done);
            end
        end
    endtask

    task automatic check_hex(input string tag, input logic [41:0] exp_h);
        logic [41:0] o;
        o = obs_hex();
        checks++;
        assert (o === exp_h) else begin
            errors++;
            $error("FAIL %s hex observed=%h expected=%h", tag, o, exp_h);
        end
    endtask

    task automatic full_scan(input string tag, input logic [23:0] v, input logic [5:0] m);
        value      = v;
        blank_mask = m;
        load       = 1'b1;
        push_scan(v, m, 6);
        tick(tag);
        load       = 1'b0;
        value      = ~v;
        blank_mask = ~m;
        repeat (7) tick(tag);
    endtask

    initial begin
        reset      = 1'b1;
        load       = 1'b0;
        value      = 24'h0;
        blank_mask = 6'h0;
        blink_en   = 1'b0;
        m_cnt      = 0;
        m_phase    = 1'b0;
        for (int n = 0; n < 6; n++) m_dig[n] = Blank;

        @(negedge clk);
        push_reset();
        tick("reset");
        reset = 1'b0;
        repeat (3) begin
            push(1'b0, 1'b0);
            tick("idle");
        end
        check_hex("idle_blank", {6{Blank}});

        full_scan("scan_012345", 24'h012345, 6'b000000);
        check_hex("final_012345", {7'b1000000, 7'b1111001, 7'b0100100,
                                   7'b0110000, 7'b0011001, 7'b0010010});

        full_scan("scan_fedcba", 24'hFEDCBA, 6'b100001);
        check_hex("final_fedcba", {Blank, 7'b0000110, 7'b0100001,
                                   7'b1000110, 7'b0000011, Blank});

        // Second load mid-scan must be dropped, not queued.
        value      = 24'h888888;
        blank_mask = 6'h0;
        load       = 1'b1;
        push_scan(24'h888888, 6'h0, 6);
        tick("busy_load");
        load = 1'b0;
        repeat (2) tick("busy_load");
        value = 24'h111111;
        load  = 1'b1;
        tick("busy_load");
        load  = 1'b0;
        repeat (4) tick("busy_load");
        push(1'b0, 1'b0);
        tick("busy_load_idle");
        check_hex("final_888888", {6{7'b0000000}});

        full_scan("scan_zero", 24'h000000, 6'h0);
        blink_en = 1'b1;
        repeat (14) begin
            push(1'b0, 1'b0);
            tick("blink");
        end
        check_hex("blink_dark", {6{Blank}});
        blink_en = 1'b0;
        #1;
        check_hex("blink_drop", {6{7'b1000000}});
        push(1'b0, 1'b0);
        tick("blink_off");
        blink_en = 1'b1;
        repeat (4) begin
            push(1'b0, 1'b0);
            tick("blink_restart");
        end
        blink_en = 1'b0;
        push(1'b0, 1'b0);
        tick("blink_off2");

        // Reset at edge k+3 of a scan.
        value      = 24'h123456;
        blank_mask = 6'h0;
        load       = 1'b1;
        push_scan(24'h123456, 6'h0, 2);
        tick("mid_reset");
        load = 1'b0;
        repeat (2) tick("mid_reset");
        reset = 1'b1;
        push_reset();
        tick("mid_reset_edge");
        reset = 1'b0;
        repeat (3) begin
            push(1'b0, 1'b0);
            tick("after_reset");
        end
        full_scan("scan_abcdef", 24'hABCDEF, 6'h0);
        check_hex("final_abcdef", {7'b0001000, 7'b0000011, 7'b1000110,
                                   7'b0100001, 7'b0000110, 7'b0001110});

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL leftover observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
